// File: rtl/fnc_vgadisplay_ctrl.sv
// Parametrised VGA timing generator with VRAM fetch, pixel replication and latency-aligned outputs.
// Optional 8-bar colour test pattern (adds port test_en) when VGA_TESTPATTERN_EN is defined.
module fnc_vgadisplay_ctrl #(
   parameter int H_PIXELS      = 640,
   parameter int H_FRONT_PORCH = 16,
   parameter int H_SYNC        = 64,
   parameter int H_BACK_PORCH  = 80,
   parameter int V_PIXELS      = 480,
   parameter int V_FRONT_PORCH = 3,
   parameter int V_SYNC        = 4,
   parameter int V_BACK_PORCH  = 13,
   parameter bit HSYNC_POL     = 1'b0,
   parameter bit VSYNC_POL     = 1'b1,
   parameter int SCALE_SHIFT   = 0,
   parameter int VRAM_LAT      = 1,
   parameter int ADDR_W        = 19,
   parameter int COLOR_W       = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 module_en,
`ifdef VGA_TESTPATTERN_EN
   input  logic                 test_en,
`endif
   output logic                 hblank,
   output logic                 vblank,
   output logic                 frame_start,
   output logic [ADDR_W-1:0]    addr,
   input  logic [3*COLOR_W-1:0] data,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [COLOR_W-1:0]   rdata,
   output logic [COLOR_W-1:0]   gdata,
   output logic [COLOR_W-1:0]   bdata
);

   localparam int HB         = H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
   localparam int HT         = HB + H_PIXELS;
   localparam int VB         = V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
   localparam int VT         = VB + V_PIXELS;
   localparam int HCW        = $clog2(HT);
   localparam int VCW        = $clog2(VT);
   localparam int LINE_STEP  = H_PIXELS >> SCALE_SHIFT;
   localparam int SCALE_MASK = (1 << SCALE_SHIFT) - 1;
`ifdef VGA_TESTPATTERN_EN
   localparam int BAR_W      = H_PIXELS / 8;
   localparam int PW         = 7;
`else
   localparam int PW         = 3;
`endif

   logic                 run_q, run_d;
   logic [HCW-1:0]       hcnt_q, hcnt_d;
   logic [VCW-1:0]       vcnt_q, vcnt_d;
   logic [ADDR_W-1:0]    line_base_q, line_base_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [PW-1:0]        pipe_q [0:VRAM_LAT];
   logic [PW-1:0]        pipe_d [0:VRAM_LAT];
   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic                 de_q, de_d;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;

   logic [HCW-1:0]       hx;
   logic [VCW-1:0]       ly;
   logic                 h_last, v_last, active, raw_hs, raw_vs;
   logic [PW-1:0]        raw, last;

   assign hblank      = hcnt_q < HCW'(HB);
   assign vblank      = vcnt_q < VCW'(VB);
   assign active      = ~hblank & ~vblank;
   assign hx          = hcnt_q - HCW'(HB);
   assign ly          = vcnt_q - VCW'(VB);
   assign h_last      = hcnt_q == HCW'(HT - 1);
   assign v_last      = vcnt_q == VCW'(VT - 1);
   assign frame_start = run_q & (hcnt_q == '0) & (vcnt_q == '0);
   assign raw_hs      = (hcnt_q >= HCW'(H_FRONT_PORCH)) & (hcnt_q < HCW'(H_FRONT_PORCH + H_SYNC));
   assign raw_vs      = (vcnt_q >= VCW'(V_FRONT_PORCH)) & (vcnt_q < VCW'(V_FRONT_PORCH + V_SYNC));

   // Pipeline word: [0] de, [1] hsync, [2] vsync, then optional {bar index, pattern select}.
   always_comb begin
      raw    = '0;
      raw[0] = active;
      raw[1] = raw_hs;
      raw[2] = raw_vs;
`ifdef VGA_TESTPATTERN_EN
      raw[3]   = test_en;
      raw[6:4] = 3'(hx / HCW'(BAR_W));
`endif
   end

   // run_q delays the start by one cycle so position (0,0) is held for a full cycle after enable.
   always_comb begin
      run_d       = module_en;
      hcnt_d      = hcnt_q;
      vcnt_d      = vcnt_q;
      line_base_d = line_base_q;
      addr_d      = addr_q;
      if (run_q) begin
         if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + VCW'(1);
         end else begin
            hcnt_d = hcnt_q + HCW'(1);
         end
         if (h_last && v_last) begin
            line_base_d = '0;
         end else if (h_last && !vblank && ((ly & VCW'(SCALE_MASK)) == VCW'(SCALE_MASK))) begin
            line_base_d = line_base_q + ADDR_W'(LINE_STEP);
         end
      end
      if (active) begin
         addr_d = line_base_q + ADDR_W'(hx >> SCALE_SHIFT);
      end
      if (!module_en) begin
         hcnt_d      = '0;
         vcnt_d      = '0;
         line_base_d = '0;
         addr_d      = '0;
      end
   end

   always_comb begin
      for (int i = 0; i <= VRAM_LAT; i++) pipe_d[i] = '0;
      if (module_en) begin
         pipe_d[0] = raw;
         for (int i = 1; i <= VRAM_LAT; i++) pipe_d[i] = pipe_q[i-1];
      end
   end

   always_comb begin
      last    = pipe_q[VRAM_LAT];
      de_d    = last[0];
      hsync_d = last[1] ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = last[2] ? VSYNC_POL : ~VSYNC_POL;
      rgb_d   = last[0] ? data : '0;
`ifdef VGA_TESTPATTERN_EN
      // Bar colour bits: R = ~bar[1], G = ~bar[2], B = ~bar[0] gives white..black order.
      if (last[0] && last[3]) begin
         rgb_d = {{COLOR_W{~last[5]}}, {COLOR_W{~last[6]}}, {COLOR_W{~last[4]}}};
      end
`endif
      if (!module_en) begin
         de_d    = 1'b0;
         hsync_d = ~HSYNC_POL;
         vsync_d = ~VSYNC_POL;
         rgb_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q       <= 1'b0;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         line_base_q <= '0;
         addr_q      <= '0;
         for (int i = 0; i <= VRAM_LAT; i++) pipe_q[i] <= '0;
         hsync_q     <= ~HSYNC_POL;
         vsync_q     <= ~VSYNC_POL;
         de_q        <= 1'b0;
         rgb_q       <= '0;
      end else begin
         run_q       <= run_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         line_base_q <= line_base_d;
         addr_q      <= addr_d;
         for (int i = 0; i <= VRAM_LAT; i++) pipe_q[i] <= pipe_d[i];
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         de_q        <= de_d;
         rgb_q       <= rgb_d;
      end
   end

   assign addr  = addr_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;
   assign de    = de_q;
   assign rdata = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign gdata = rgb_q[2*COLOR_W-1:COLOR_W];
   assign bdata = rgb_q[COLOR_W-1:0];

endmodule

// File: doc/fnc_vgadisplay_ctrl.md
# fnc_vgadisplay_ctrl

Parametrised VGA display controller, next generation of the fixed 640x480 controller in the VGA peripheral. It generates programmable H/V timing with selectable sync polarity, fetches pixels from VRAM with integer pixel replication (1x/2x/4x), and compensates a configurable VRAM read latency so that sync, data-enable and RGB leave the block mutually aligned. It runs in the pixel clock domain; status outputs go to the register block, which performs the clock-domain crossing.

## Interface
Parameters:
- H_PIXELS, 640, active pixels per line
- H_FRONT_PORCH / H_SYNC / H_BACK_PORCH, 16 / 64 / 80, horizontal blanking segments in pixels
- V_PIXELS, 480, active lines
- V_FRONT_PORCH / V_SYNC / V_BACK_PORCH, 3 / 4 / 13, vertical blanking segments in lines
- HSYNC_POL / VSYNC_POL, 0 / 1, active level of the sync pulse (0 = negative)
- SCALE_SHIFT, 0, replication factor 2^SCALE_SHIFT in both axes; legal values 0..2
- VRAM_LAT, 1, VRAM read latency in cycles from addr to data; legal values 1..4
- ADDR_W, 19, VRAM address width
- COLOR_W, 4, bits per colour channel

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- module_en  in  1  enable; low forces the reset state synchronously
- hblank  out  1  horizontal blanking status, undelayed
- vblank  out  1  vertical blanking status, undelayed
- frame_start  out  1  one-cycle pulse on counter wrap to (0,0)
- addr  out  ADDR_W  registered VRAM read address
- data  in  3*COLOR_W  VRAM pixel {R,G,B}, valid VRAM_LAT cycles after addr
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- de  out  1  registered data enable
- rdata / gdata / bdata  out  COLOR_W each  registered colour channels

## Operation
- Line order: front porch, sync, back porch, active. hcnt runs 0..HT-1 with HT = sum of the H parameters. vcnt increments when hcnt = HT-1 and wraps at VT-1.
- hblank = hcnt < H_FRONT_PORCH+H_SYNC+H_BACK_PORCH. vblank is defined the same way on vcnt. Both are combinational from the counters.
- The raw hsync is active while hcnt is in [H_FRONT_PORCH, H_FRONT_PORCH+H_SYNC-1]. The raw vsync is active for lines [V_FRONT_PORCH, V_FRONT_PORCH+V_SYNC-1], changing at line boundaries. Raw de = ~hblank & ~vblank.
- Address generation: hx = active pixel index, ly = active line index.
  - addr = line_base + (hx >> SCALE_SHIFT).
  - line_base starts at 0 each frame.
  - line_base advances by H_PIXELS>>SCALE_SHIFT at the end of every active line whose (ly mod 2^SCALE_SHIFT) = 2^SCALE_SHIFT-1.
  - During blanking, addr holds its last value.
- The raw hsync, vsync and de pass through a shift pipeline of depth VRAM_LAT+1 so they line up with the returned data.
- RGB output: when the delayed de is 1, RGB = data; otherwise RGB = 0.
- Sync outputs are driven at their parameterised polarity. The inactive level is ~POL.
- module_en low:
  - Counters, line_base, addr, the delay pipeline and all outputs go to their reset values on the next clock.
  - Restart after module_en rises begins at (0,0) with frame_start pulsed.

## Timing
- Reset values:
  - hcnt, vcnt, line_base, addr = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - de = 0, rgb = 0, frame_start = 0
- addr is registered. It presents the address of the counter position one cycle later.
- hsync, vsync, de and RGB all lag the counter position by VRAM_LAT+2 cycles and are mutually aligned.
- frame_start is high for the single cycle in which hcnt = vcnt = 0.
- At the last cycle of the frame (hcnt = HT-1, vcnt = VT-1), line_base is cleared. The first active pixel of the next frame reads address 0.
- If a frame wrap coincides with a line_base advance, the clear wins.
- Address width rule: (H_PIXELS>>S)*(V_PIXELS>>S) must be ≤ 2^ADDR_W. Arithmetic wraps modulo 2^ADDR_W.

## Configuration
- VGA_TESTPATTERN_EN defined:
  - Adds input port test_en (1 bit).
  - When test_en = 1, RGB in the active area comes from an internal 8-bar colour pattern instead of data. The bar index is hx[...] scaled so that 8 equal-width bars span H_PIXELS. Bar order: white, yellow, cyan, green, magenta, red, blue, black, full-scale values.
  - The pattern uses the same delay pipeline, so its latency equals the data path.
  - addr still runs normally.
- VGA_TESTPATTERN_EN undefined: no test_en port and no pattern logic. RGB comes only from data.

## Test plan
- Defaults, reset release with module_en = 1:
  - hsync low for 64 cycles every 800.
  - vsync high for 4 lines every 500.
  - de high for 640 cycles per line on 480 lines.
  - frame_start period = 400000 cycles.
- SCALE_SHIFT = 1:
  - Line 0 addr sequence is 0,0,1,1,…,319,319.
  - Active line 1 repeats line 0.
  - Active line 2 starts at 320.
  - The last active address is 76799; the next frame starts at 0.
- VRAM_LAT = 3, with a bench VRAM model returning data = addr[11:0]:
  - The first de cycle carries the RGB of address 0.
  - de, hsync and RGB edges are all offset 5 cycles from the counter.
  - RGB = 0 outside de.
- HSYNC_POL = 1, VSYNC_POL = 0: pulse levels invert. Reset levels are hsync = 0 and vsync = 1.
- module_en dropped mid-active line 100:
  - All outputs return to reset values on the next clock.
  - After re-enable, frame_start pulses immediately and addr restarts at 0.
- VGA_TESTPATTERN_EN with test_en = 1, defaults:
  - Pixels 0–79 = FFF, 80–159 = FF0, and so on through 560–639 = 000.
  - Output is independent of data.
